ctrl_pipe_hazard: RTL and testbench

- Carries the decoder's control bundle from the D stage through the E, M and W pipeline registers of the 5-stage CPU.
- Detects data hazards using Tuse/Tnew and produces the stall signal and all forwarding-mux selects.
- Sits between the D-stage control signal generator and the E/M/W datapath. It is the downstream consumer of the decoder's control outputs.

---
 rtl/ctrl_pipe_hazard.sv | 128 ++++++++++++
 tb/tb_ctrl_pipe_hazard.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_hazard.sv
// Control pipeline for the 5-stage CPU: carries the decoded control bundle
// through E/M/W and resolves data hazards with Tuse/Tnew stall and forward selects.
module ctrl_pipe_hazard #(
    parameter int         RA_W    = 5,
    parameter logic [1:0] PC8_SEL = 2'b10,
    parameter logic [1:0] DM_SEL  = 2'b01
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      D_WDCtrl,
    input  logic [2:0]      D_ALUCtrl,
    input  logic            D_ALUBCtrl,
    input  logic            D_DM_WE,
    input  logic            D_DM_RE,
    input  logic            D_GRFWE,
    input  logic [RA_W-1:0] D_rs,
    input  logic [RA_W-1:0] D_rt,
    input  logic [RA_W-1:0] D_wa,
    input  logic [1:0]      D_Tuse_rs,
    input  logic [1:0]      D_Tuse_rt,
    output logic            stall,
    output logic [2:0]      E_ALUCtrl,
    output logic            E_ALUBCtrl,
    output logic            M_DM_WE,
    output logic            M_DM_RE,
    output logic [1:0]      W_WDCtrl,
    output logic            W_GRFWE,
    output logic [RA_W-1:0] W_wa,
    output logic [1:0]      FwdD_rs,
    output logic [1:0]      FwdD_rt,
    output logic [1:0]      FwdE_rs,
    output logic [1:0]      FwdE_rt,
    output logic [1:0]      FwdM_rt
);

    typedef struct packed {
        logic [1:0]      wdctrl;
        logic [2:0]      aluctrl;
        logic            alubctrl;
        logic            dm_we;
        logic            dm_re;
        logic            grfwe;
        logic [RA_W-1:0] wa;
    } ctrl_t;

    ctrl_t           d_c, e_q, m_q, w_q;
    logic [RA_W-1:0] e_rs, e_rt, m_rs, m_rt;
    logic [1:0]      tnew_e, tnew_m;
    logic            stall_rs, stall_rt;

    assign d_c = '{wdctrl: D_WDCtrl, aluctrl: D_ALUCtrl, alubctrl: D_ALUBCtrl,
                   dm_we: D_DM_WE, dm_re: D_DM_RE, grfwe: D_GRFWE, wa: D_wa};

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q  <= '0;
            m_q  <= '0;
            w_q  <= '0;
            e_rs <= '0;
            e_rt <= '0;
            m_rs <= '0;
            m_rt <= '0;
        end else begin
            m_q  <= e_q;
            m_rs <= e_rs;
            m_rt <= e_rt;
            w_q  <= m_q;
            // A stalled D instruction reissues next cycle; E gets a bubble meanwhile.
            if (stall) begin
                e_q  <= '0;
                e_rs <= '0;
                e_rt <= '0;
            end else begin
                e_q  <= d_c;
                e_rs <= D_rs;
                e_rt <= D_rt;
            end
        end
    end

    function automatic logic hit(input ctrl_t s, input logic [RA_W-1:0] r);
        return s.grfwe && (s.wa == r) && (r != '0);
    endfunction

    always_comb begin
        tnew_e = 2'd1;
        if (e_q.wdctrl == DM_SEL)       tnew_e = 2'd2;
        else if (e_q.wdctrl == PC8_SEL) tnew_e = 2'd0;
        tnew_m = (m_q.wdctrl == DM_SEL) ? 2'd1 : 2'd0;
    end

    assign stall_rs = (D_Tuse_rs != 2'd3) &&
                      ((hit(e_q, D_rs) && (tnew_e > D_Tuse_rs)) ||
                       (hit(m_q, D_rs) && (tnew_m > D_Tuse_rs)));
    assign stall_rt = (D_Tuse_rt != 2'd3) &&
                      ((hit(e_q, D_rt) && (tnew_e > D_Tuse_rt)) ||
                       (hit(m_q, D_rt) && (tnew_m > D_Tuse_rt)));
    assign stall    = stall_rs || stall_rt;

    // Nearest producer wins; a load in M has no data yet, so it cannot forward.
    function automatic logic [1:0] fwd_d(input logic [RA_W-1:0] r);
        if (hit(e_q, r) && e_q.wdctrl == PC8_SEL)     return 2'd1;
        else if (hit(m_q, r) && m_q.wdctrl != DM_SEL) return 2'd2;
        else if (hit(w_q, r))                         return 2'd3;
        else                                          return 2'd0;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [RA_W-1:0] r);
        if (hit(m_q, r) && m_q.wdctrl != DM_SEL) return 2'd2;
        else if (hit(w_q, r))                    return 2'd3;
        else                                     return 2'd0;
    endfunction

    assign FwdD_rs = fwd_d(D_rs);
    assign FwdD_rt = fwd_d(D_rt);
    assign FwdE_rs = fwd_e(e_rs);
    assign FwdE_rt = fwd_e(e_rt);
    assign FwdM_rt = hit(w_q, m_rt) ? 2'd3 : 2'd0;

    assign E_ALUCtrl  = e_q.aluctrl;
    assign E_ALUBCtrl = e_q.alubctrl;
    assign M_DM_WE    = m_q.dm_we;
    assign M_DM_RE    = m_q.dm_re;
    assign W_WDCtrl   = w_q.wdctrl;
    assign W_GRFWE    = w_q.grfwe;
    assign W_wa       = w_q.wa;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Scoreboard bench for ctrl_pipe_hazard: directed instruction stream with
// hand-computed per-cycle expectations, checked by an independent monitor.
module tb_ctrl_pipe_hazard;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] D_WDCtrl;
    logic [2:0] D_ALUCtrl;
    logic       D_ALUBCtrl, D_DM_WE, D_DM_RE, D_GRFWE;
    logic [4:0] D_rs, D_rt, D_wa;
    logic [1:0] D_Tuse_rs, D_Tuse_rt;
    logic       stall;
    logic [2:0] E_ALUCtrl;
    logic       E_ALUBCtrl, M_DM_WE, M_DM_RE, W_GRFWE;
    logic [1:0] W_WDCtrl;
    logic [4:0] W_wa;
    logic [1:0] FwdD_rs, FwdD_rt, FwdE_rs, FwdE_rt, FwdM_rt;

    ctrl_pipe_hazard dut (
        .clk(clk), .reset(reset),
        .D_WDCtrl(D_WDCtrl), .D_ALUCtrl(D_ALUCtrl), .D_ALUBCtrl(D_ALUBCtrl),
        .D_DM_WE(D_DM_WE), .D_DM_RE(D_DM_RE), .D_GRFWE(D_GRFWE),
        .D_rs(D_rs), .D_rt(D_rt), .D_wa(D_wa),
        .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
        .stall(stall), .E_ALUCtrl(E_ALUCtrl), .E_ALUBCtrl(E_ALUBCtrl),
        .M_DM_WE(M_DM_WE), .M_DM_RE(M_DM_RE),
        .W_WDCtrl(W_WDCtrl), .W_GRFWE(W_GRFWE), .W_wa(W_wa),
        .FwdD_rs(FwdD_rs), .FwdD_rt(FwdD_rt), .FwdE_rs(FwdE_rs),
        .FwdE_rt(FwdE_rt), .FwdM_rt(FwdM_rt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] wd;
        logic [2:0] alu;
        logic       alub, we, re, grfwe;
        logic [4:0] rs, rt, wa;
        logic [1:0] tur, tut;
    } d_t;

    typedef struct {
        string       nm;
        logic        st;
        logic [9:0]  fwd;
        logic [13:0] regs;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   passed = 0;

    function automatic logic [9:0] F(input logic [1:0] drs, drt, ers, ert, mrt);
        return {drs, drt, ers, ert, mrt};
    endfunction

    function automatic logic [13:0] R(input logic [2:0] e_alu, input logic e_alub,
                                      input logic m_we, m_re, input logic [1:0] w_wd,
                                      input logic w_grfwe, input logic [4:0] w_wa);
        return {e_alu, e_alub, m_we, m_re, w_wd, w_grfwe, w_wa};
    endfunction

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            total += 3;
            if (stall === mon_e.st) passed++;
            else $display("FAIL %s stall: got %b want %b", mon_e.nm, stall, mon_e.st);
            if ({FwdD_rs, FwdD_rt, FwdE_rs, FwdE_rt, FwdM_rt} === mon_e.fwd) passed++;
            else $display("FAIL %s fwd{Drs,Drt,Ers,Ert,Mrt}: got %b want %b", mon_e.nm,
                          {FwdD_rs, FwdD_rt, FwdE_rs, FwdE_rt, FwdM_rt}, mon_e.fwd);
            if ({E_ALUCtrl, E_ALUBCtrl, M_DM_WE, M_DM_RE, W_WDCtrl, W_GRFWE, W_wa} === mon_e.regs)
                passed++;
            else $display("FAIL %s regs: got %b want %b", mon_e.nm,
                          {E_ALUCtrl, E_ALUBCtrl, M_DM_WE, M_DM_RE, W_WDCtrl, W_GRFWE, W_wa},
                          mon_e.regs);
        end
    end

    task automatic cyc(input d_t d, input string nm, input logic st,
                       input logic [9:0] fwd, input logic [13:0] regs);
        exp_t e;
        {D_WDCtrl, D_ALUCtrl, D_ALUBCtrl, D_DM_WE, D_DM_RE, D_GRFWE,
         D_rs, D_rt, D_wa, D_Tuse_rs, D_Tuse_rt} = d;
        e.nm = nm; e.st = st; e.fwd = fwd; e.regs = regs;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    //                wd     alu   b  we re g  rs     rt     wa     tur   tut
    localparam d_t NOP   = {2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd3, 2'd3};
    localparam d_t LW1   = {2'b01, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 5'd1, 5'd1, 2'd1, 2'd3};
    localparam d_t ADDU4 = {2'b00, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd6, 5'd4, 2'd1, 2'd1};
    localparam d_t ADDU2 = {2'b00, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd8, 5'd2, 2'd1, 2'd1};
    localparam d_t BEQ   = {2'b00, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 5'd0, 5'd0, 2'd0, 2'd0};
    localparam d_t JAL   = {2'b10, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd31, 2'd3, 2'd3};
    localparam d_t JR    = {2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd31, 5'd0, 5'd0, 2'd0, 2'd3};
    localparam d_t LW3   = {2'b01, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 5'd3, 5'd3, 2'd1, 2'd3};
    localparam d_t SW    = {2'b00, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 5'd3, 5'd0, 2'd1, 2'd2};
    localparam d_t ORI0  = {2'b00, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 2'd1, 2'd3};
    localparam d_t ADDU5 = {2'b00, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 2'd1, 2'd1};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        {D_WDCtrl, D_ALUCtrl, D_ALUBCtrl, D_DM_WE, D_DM_RE, D_GRFWE,
         D_rs, D_rt, D_wa, D_Tuse_rs, D_Tuse_rt} = NOP;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        cyc(NOP,   "reset_state", 0, F(0,0,0,0,0), R(0,0,0,0,0,0,0));
        // Load-use: one stall, bubble, then W forward into E.
        cyc(LW1,   "lw_issue",    0, F(0,0,0,0,0), R(0,0,0,0,0,0,0));
        cyc(ADDU4, "lu_stall",    1, F(0,0,0,0,0), R(2,1,0,0,0,0,0));
        cyc(ADDU4, "lu_resume",   0, F(0,0,0,0,0), R(0,0,0,1,0,0,0));
        cyc(NOP,   "lu_fwdE_W",   0, F(0,0,3,0,0), R(2,0,0,0,2'b01,1,1));
        // beq after addu: stall, then M forward into D.
        cyc(ADDU2, "addu2_issue", 0, F(0,0,0,0,0), R(0,0,0,0,0,0,0));
        cyc(BEQ,   "beq_stall",   1, F(0,0,0,0,0), R(2,0,0,0,2'b00,1,4));
        cyc(BEQ,   "beq_fwdD_M",  0, F(2,0,0,0,0), R(0,0,0,0,0,0,0));
        // jal then jr $31: PC8 forwarded from E with no stall.
        cyc(JAL,   "jal_issue",   0, F(0,0,3,0,0), R(6,0,0,0,2'b00,1,2));
        cyc(JR,    "jr_fwdD_E",   0, F(1,0,0,0,0), R(0,0,0,0,0,0,0));
        // lw $3 then sw $3 (Tuse_rt=2): no stall, W forward into M.
        cyc(LW3,   "lw3_issue",   0, F(0,0,2,0,0), R(0,0,0,0,0,0,0));
        cyc(SW,    "sw_nostall",  0, F(0,0,0,0,0), R(2,1,0,0,2'b10,1,31));
        cyc(NOP,   "sw_in_E",     0, F(0,0,0,0,0), R(2,1,0,1,2'b00,0,0));
        cyc(ORI0,  "sw_fwdM_W",   0, F(0,0,0,0,3), R(0,0,1,0,2'b01,1,3));
        // $0 writer never matches.
        cyc(ADDU5, "zero_reg",    0, F(0,0,0,0,0), R(3,1,0,0,2'b00,0,0));
        // Reset during a load-use stall.
        cyc(LW1,   "lw_again",    0, F(0,0,0,0,0), R(2,0,0,0,0,0,0));
        reset = 1'b1;
        cyc(ADDU4, "stall_at_rst",1, F(0,0,2,0,0), R(2,1,0,0,2'b00,1,0));
        reset = 1'b0;
        cyc(ADDU4, "post_reset",  0, F(0,0,0,0,0), R(0,0,0,0,0,0,0));
        cyc(NOP,   "resume_E",    0, F(0,0,0,0,0), R(2,0,0,0,0,0,0));
        cyc(NOP,   "resume_M",    0, F(0,0,0,0,0), R(0,0,0,0,0,0,0));
        cyc(NOP,   "resume_W",    0, F(0,0,0,0,0), R(0,0,0,0,2'b00,1,4));

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
